// File: rtl/pe_pkg.sv
// Shared definitions for the output-stationary PE: activation encodings and
// the tile-accumulation state type.
package pe_pkg;

  localparam int ACT_BYPASS = 0;
  localparam int ACT_RELU   = 1;
  localparam int ACT_LEAKY  = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } pe_state_e;

endpackage

// File: rtl/pe_act.sv
// Combinational activation applied to a finished tile sum.
module pe_act
  import pe_pkg::*;
#(
  parameter int ACC_WIDTH   = 32,
  parameter int ACT_MODE    = ACT_RELU,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic signed [ACC_WIDTH-1:0] sum_i,
  output logic signed [ACC_WIDTH-1:0] act_o
);

  // Negative sums are zeroed (ReLU) or scaled down (leaky); others pass through
  always_comb begin
    act_o = sum_i;
    if (sum_i[ACC_WIDTH-1]) begin
      case (ACT_MODE)
        ACT_RELU:  act_o = '0;
        ACT_LEAKY: act_o = sum_i >>> LEAKY_SHIFT;
        default:   act_o = sum_i;
      endcase
    end
  end

endmodule

// File: rtl/pe_os_acc.sv
// Output-stationary systolic PE: forwards A east / B south after one cycle,
// accumulates A*B over a first..last tile and hands the activated sum out
// through a single-entry valid/ready result register.
module pe_os_acc
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ACC_WIDTH   = 32,
  parameter int ACT_MODE    = ACT_RELU,
  parameter int LEAKY_SHIFT = 3,
  parameter int SATURATE    = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] a_in,
  input  logic                         a_valid_in,
  input  logic                         first_in,
  input  logic                         last_in,
  input  logic signed [DATA_WIDTH-1:0] b_in,
  input  logic                         b_valid_in,
  output logic signed [DATA_WIDTH-1:0] a_out,
  output logic                         a_valid_out,
  output logic                         first_out,
  output logic                         last_out,
  output logic signed [DATA_WIDTH-1:0] b_out,
  output logic                         b_valid_out,
  output logic signed [ACC_WIDTH-1:0]  res_out,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic signed [ACC_WIDTH-1:0]  pre_act,
  output logic                         sat_flag,
  output logic                         overrun,
  output logic                         proto_err
);

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // stage-1 operand registers
  logic signed [DATA_WIDTH-1:0] a_q, b_q;
  logic                         a_vld_q, b_vld_q, first_q, last_q;

  // accumulation state
  pe_state_e                    state_q, state_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                         sat_q, sat_d;
  logic                         perr_q, perr_d;
  logic                         ld_res;

  // result register
  logic signed [ACC_WIDTH-1:0]  res_q, res_d, act_val;
  logic                         res_vld_q, res_vld_d;
  logic                         ovr_q, ovr_d;

  // datapath
  logic                         beat;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [ACC_WIDTH:0]    sum_ext;
  logic                         ovf;
  logic signed [ACC_WIDTH-1:0]  sum_sat;

  // Stage 1 captures both operand streams every cycle, valid or not
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      a_vld_q <= 1'b0;
      b_vld_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      a_q     <= a_in;
      b_q     <= b_in;
      a_vld_q <= a_valid_in;
      b_vld_q <= b_valid_in;
      first_q <= first_in;
      last_q  <= last_in;
    end
  end

  assign a_out       = a_q;
  assign a_valid_out = a_vld_q;
  assign first_out   = first_q;
  assign last_out    = last_q;
  assign b_out       = b_q;
  assign b_valid_out = b_vld_q;

  // Full-precision product; ACC_WIDTH >= 2*DATA_WIDTH so it always fits.
  // The sum carries one guard bit so overflow shows as a sign disagreement.
  assign beat     = a_vld_q & b_vld_q;
  assign prod_ext = ACC_WIDTH'(a_q) * ACC_WIDTH'(b_q);
  assign sum_ext  = (ACC_WIDTH+1)'(acc_q) + (ACC_WIDTH+1)'(prod_ext);
  assign ovf      = sum_ext[ACC_WIDTH] ^ sum_ext[ACC_WIDTH-1];

  // Clamp toward the true sign on overflow, otherwise keep the low bits
  always_comb begin
    sum_sat = sum_ext[ACC_WIDTH-1:0];
    if ((SATURATE != 0) && ovf) sum_sat = sum_ext[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
  end

  // Tile FSM: first starts (or restarts) a tile, last closes it and loads
  // the result; a beat outside a tile without first is a protocol error
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    perr_d  = 1'b0;
    ld_res  = 1'b0;
    if (beat) begin
      if (first_q) begin
        acc_d   = prod_ext;
        sat_d   = 1'b0;
        state_d = ST_ACC;
        if (last_q) begin
          ld_res  = 1'b1;
          state_d = ST_IDLE;
        end
      end else if (state_q == ST_ACC) begin
        acc_d = sum_sat;
        sat_d = sat_q | ((SATURATE != 0) && ovf);
        if (last_q) begin
          ld_res  = 1'b1;
          state_d = ST_IDLE;
        end
      end else begin
        perr_d = 1'b1;
      end
    end
  end

  pe_act #(
    .ACC_WIDTH  (ACC_WIDTH),
    .ACT_MODE   (ACT_MODE),
    .LEAKY_SHIFT(LEAKY_SHIFT)
  ) u_act (
    .sum_i(acc_d),
    .act_o(act_val)
  );

  // Accumulator, sticky saturation flag and error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      perr_q  <= perr_d;
    end
  end

  // A new result always wins; overwriting an unconsumed one flags overrun
  always_comb begin
    res_d     = res_q;
    res_vld_d = res_vld_q;
    ovr_d     = 1'b0;
    if (ld_res) begin
      res_d     = act_val;
      res_vld_d = 1'b1;
      ovr_d     = res_vld_q & ~res_ready;
    end else if (res_vld_q && res_ready) begin
      res_vld_d = 1'b0;
    end
  end

  // Result holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q     <= '0;
      res_vld_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      res_q     <= res_d;
      res_vld_q <= res_vld_d;
      ovr_q     <= ovr_d;
    end
  end

  assign res_out   = res_q;
  assign res_valid = res_vld_q;
  assign pre_act   = acc_q;
  assign sat_flag  = sat_q;
  assign overrun   = ovr_q;
  assign proto_err = perr_q;

endmodule

// File: tb/tb_pe_os_acc.sv
// Bench for pe_os_acc: three configurations share one stimulus stream and
// are compared every cycle against an integer tile model.
module tb_pe_os_acc;

  localparam int DW = 16;
  localparam int AW = 32;
  localparam int NC = 3;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  // cfg0: ReLU/saturate, cfg1: leaky>>1/saturate, cfg2: bypass/wrap
  int c_mode[NC] = '{1, 2, 0};
  int c_sh[NC]   = '{3, 1, 3};
  bit c_sat[NC]  = '{1'b1, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DW-1:0] a_in = '0, b_in = '0;
  logic a_valid_in = 1'b0, b_valid_in = 1'b0, first_in = 1'b0, last_in = 1'b0;
  logic res_ready = 1'b1;

  logic [DW-1:0] a_out[NC], b_out[NC];
  logic          a_valid_out[NC], first_out[NC], last_out[NC], b_valid_out[NC];
  logic [AW-1:0] res_out[NC], pre_act[NC];
  logic          res_valid[NC], sat_flag[NC], overrun[NC], proto_err[NC];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pe_os_acc #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .ACT_MODE(1), .LEAKY_SHIFT(3), .SATURATE(1)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .a_in(a_in), .a_valid_in(a_valid_in), .first_in(first_in), .last_in(last_in),
    .b_in(b_in), .b_valid_in(b_valid_in),
    .a_out(a_out[0]), .a_valid_out(a_valid_out[0]), .first_out(first_out[0]), .last_out(last_out[0]),
    .b_out(b_out[0]), .b_valid_out(b_valid_out[0]),
    .res_out(res_out[0]), .res_valid(res_valid[0]), .res_ready(res_ready),
    .pre_act(pre_act[0]), .sat_flag(sat_flag[0]), .overrun(overrun[0]), .proto_err(proto_err[0]));

  pe_os_acc #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .ACT_MODE(2), .LEAKY_SHIFT(1), .SATURATE(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_in(a_in), .a_valid_in(a_valid_in), .first_in(first_in), .last_in(last_in),
    .b_in(b_in), .b_valid_in(b_valid_in),
    .a_out(a_out[1]), .a_valid_out(a_valid_out[1]), .first_out(first_out[1]), .last_out(last_out[1]),
    .b_out(b_out[1]), .b_valid_out(b_valid_out[1]),
    .res_out(res_out[1]), .res_valid(res_valid[1]), .res_ready(res_ready),
    .pre_act(pre_act[1]), .sat_flag(sat_flag[1]), .overrun(overrun[1]), .proto_err(proto_err[1]));

  pe_os_acc #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .ACT_MODE(0), .LEAKY_SHIFT(3), .SATURATE(0)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .a_in(a_in), .a_valid_in(a_valid_in), .first_in(first_in), .last_in(last_in),
    .b_in(b_in), .b_valid_in(b_valid_in),
    .a_out(a_out[2]), .a_valid_out(a_valid_out[2]), .first_out(first_out[2]), .last_out(last_out[2]),
    .b_out(b_out[2]), .b_valid_out(b_valid_out[2]),
    .res_out(res_out[2]), .res_valid(res_valid[2]), .res_ready(res_ready),
    .pre_act(pre_act[2]), .sat_flag(sat_flag[2]), .overrun(overrun[2]), .proto_err(proto_err[2]));

  // reference model state
  longint m_acc[NC], m_res[NC];
  bit     m_tile[NC], m_sat[NC], m_rv[NC], m_ovr[NC], m_perr[NC];
  longint p_a, p_b;
  bit     p_av, p_bv, p_f, p_l;

  function automatic longint wrap32(input longint v);
    logic signed [31:0] t;
    t = v[31:0];
    return longint'(t);
  endfunction

  function automatic longint act(input int c, input longint v);
    if (v >= 0) return v;
    if (c_mode[c] == 1) return 0;
    if (c_mode[c] == 2) return v >>> c_sh[c];
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_acc[c] = 0; m_res[c] = 0; m_tile[c] = 0; m_sat[c] = 0;
      m_rv[c] = 0; m_ovr[c] = 0; m_perr[c] = 0;
    end
    p_a = 0; p_b = 0; p_av = 0; p_bv = 0; p_f = 0; p_l = 0;
  endtask

  // One rising edge: consume operands registered on the previous edge,
  // then register the operands presented now.
  task automatic model_edge();
    longint prod, s;
    bit ld;
    for (int c = 0; c < NC; c++) begin
      ld = 0;
      m_perr[c] = 0;
      if (p_av && p_bv) begin
        prod = p_a * p_b;
        if (p_f) begin
          m_acc[c] = prod; m_sat[c] = 0; m_tile[c] = 1; ld = p_l;
        end else if (m_tile[c]) begin
          s = m_acc[c] + prod;
          if (c_sat[c]) begin
            if (s > MAXV) begin s = MAXV; m_sat[c] = 1; end
            else if (s < MINV) begin s = MINV; m_sat[c] = 1; end
          end else begin
            s = wrap32(s);
          end
          m_acc[c] = s; ld = p_l;
        end else begin
          m_perr[c] = 1;
        end
        if (ld) m_tile[c] = 0;
      end
      m_ovr[c] = ld && m_rv[c] && !res_ready;
      if (ld) begin m_rv[c] = 1; m_res[c] = act(c, m_acc[c]); end
      else if (m_rv[c] && res_ready) m_rv[c] = 0;
    end
    p_a = longint'($signed(a_in)); p_b = longint'($signed(b_in));
    p_av = a_valid_in; p_bv = b_valid_in; p_f = first_in; p_l = last_in;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    logic [31:0] ea, eb;
    ea = 32'(p_a[DW-1:0]);
    eb = 32'(p_b[DW-1:0]);
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("a_out[%0d]", c), 32'(a_out[c]), ea);
      chk($sformatf("b_out[%0d]", c), 32'(b_out[c]), eb);
      chk($sformatf("fwd_ctl[%0d]", c),
          {28'd0, a_valid_out[c], b_valid_out[c], first_out[c], last_out[c]},
          {28'd0, p_av, p_bv, p_f, p_l});
      chk($sformatf("res_out[%0d]", c), res_out[c], m_res[c][31:0]);
      chk($sformatf("pre_act[%0d]", c), pre_act[c], m_acc[c][31:0]);
      chk($sformatf("flags[%0d]", c),
          {28'd0, res_valid[c], sat_flag[c], overrun[c], proto_err[c]},
          {28'd0, m_rv[c], m_sat[c], m_ovr[c], m_perr[c]});
    end
  endtask

  task automatic drive(input int a, input int b, input bit av, input bit bv, input bit f, input bit l);
    a_in = a[DW-1:0]; b_in = b[DW-1:0];
    a_valid_in = av; b_valid_in = bv; first_in = f; last_in = l;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk_all();
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // reset state
    model_reset();
    #3;
    chk_all();
    @(negedge clk);
    rst_n = 1'b1;

    // A valid without B: forwarded one cycle later, no accumulate
    drive(16'h1234, 16'h0055, 1, 0, 0, 0);
    step();
    chk("fwd_a", 32'(a_out[0]), 32'h1234);
    chk("fwd_av", 32'(a_valid_out[0]), 32'd1);
    idle(1);
    chk("no_mac_pre", pre_act[0], 32'd0);

    // beat without first while idle
    drive(5, 5, 1, 1, 0, 0);
    step();
    idle(1);
    chk("proto_err", 32'(proto_err[0]), 32'd1);
    chk("proto_pre", pre_act[0], 32'd0);
    idle(1);
    chk("proto_pulse", 32'(proto_err[0]), 32'd0);

    // 1*4 + 2*5 + 3*6
    res_ready = 1'b1;
    drive(1, 4, 1, 1, 1, 0); step();
    drive(2, 5, 1, 1, 0, 0); step();
    drive(3, 6, 1, 1, 0, 1); step();
    idle(1);
    chk("dot3_res", res_out[0], 32'd32);
    chk("dot3_vld", 32'(res_valid[0]), 32'd1);
    idle(1);
    chk("dot3_vld_drop", 32'(res_valid[0]), 32'd0);

    // negative sum through each activation
    drive(-2, 5, 1, 1, 1, 0); step();
    drive(3, 1, 1, 1, 0, 1); step();
    idle(1);
    chk("relu_res", res_out[0], 32'd0);
    chk("relu_pre", pre_act[0], -32'sd7);
    chk("leaky_res", res_out[1], -32'sd4);
    chk("bypass_res", res_out[2], -32'sd7);
    idle(1);

    // saturation / wrap on 3 * 32767^2
    drive(32767, 32767, 1, 1, 1, 0); step();
    drive(32767, 32767, 1, 1, 0, 0); step();
    drive(32767, 32767, 1, 1, 0, 1); step();
    idle(1);
    chk("sat_res", res_out[0], 32'h7fffffff);
    chk("sat_flag", 32'(sat_flag[0]), 32'd1);
    chk("wrap_flag", 32'(sat_flag[2]), 32'd0);
    drive(1, 1, 1, 1, 1, 1); step();
    idle(1);
    chk("sat_clear", 32'(sat_flag[0]), 32'd0);
    idle(2);

    // back-to-back results with consumer stalled
    res_ready = 1'b0;
    drive(3, 3, 1, 1, 1, 1); step();
    drive(2, 2, 1, 1, 1, 1); step();
    chk("ovr_first", res_out[0], 32'd9);
    idle(1);
    chk("ovr_pulse", 32'(overrun[0]), 32'd1);
    chk("ovr_res", res_out[0], 32'd4);
    idle(2);
    chk("ovr_hold", res_out[0], 32'd4);
    chk("ovr_hold_vld", 32'(res_valid[0]), 32'd1);
    chk("ovr_one_cycle", 32'(overrun[0]), 32'd0);
    res_ready = 1'b1;
    idle(1);
    chk("ovr_drain", 32'(res_valid[0]), 32'd0);

    // asynchronous reset mid-tile
    drive(4, 4, 1, 1, 1, 0); step();
    drive(5, 5, 1, 1, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    model_edge();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_all();
    chk("rst_pre", pre_act[0], 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(7, -3, 1, 1, 1, 1); step();
    idle(1);
    chk("post_rst_res", res_out[2], -32'sd21);
    idle(1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      int a, b;
      if ($urandom_range(0, 3) == 0) begin
        a = $urandom_range(0, 1) ? 32767 : -32768;
        b = $urandom_range(0, 1) ? 32767 : -32768;
      end else begin
        a = int'($urandom_range(0, 65535)) - 32768;
        b = int'($urandom_range(0, 65535)) - 32768;
      end
      drive(a, b, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0);
      res_ready = $urandom_range(0, 2) != 0;
      step();
    end
    res_ready = 1'b1;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_os_acc.md
PE_OS_ACC -- requirements
Module: pe_os_acc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, operand width (signed).
REQ-002 SHALL have parameter ACC_WIDTH, default 32, accumulator/result width (signed); SHALL be at least 2*DATA_WIDTH.
REQ-003 SHALL have parameter ACT_MODE, default 1: 0 = bypass, 1 = ReLU, 2 = leaky ReLU (arithmetic right shift).
REQ-004 SHALL have parameter LEAKY_SHIFT, default 3, shift amount for ACT_MODE 2.
REQ-005 SHALL have parameter SATURATE, default 1: 1 = clamp on overflow, 0 = wrap.
REQ-006 Ports: clk  in  1  single clock; all state on rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 a_in  in  DATA_WIDTH  signed operand from west; a_valid_in  in  1; first_in  in  1  tile start; last_in  in  1  tile end (first/last travel with A).
REQ-009 b_in  in  DATA_WIDTH  signed operand from north; b_valid_in  in  1.
REQ-010 a_out, a_valid_out, first_out, last_out  out  DATA_WIDTH/1/1/1  registered east forwarding.
REQ-011 b_out, b_valid_out  out  DATA_WIDTH/1  registered south forwarding.
REQ-012 res_out  out  ACC_WIDTH  activated result; res_valid  out  1; res_ready  in  1.
REQ-013 pre_act  out  ACC_WIDTH  raw accumulator (debug); sat_flag  out  1  sticky per tile; overrun  out  1  one-cycle pulse; proto_err  out  1  one-cycle pulse.

Function
REQ-014 Stage 1 SHALL register all west/north inputs every cycle unconditionally; forwarding outputs SHALL equal stage-1 registers (1-cycle latency).
REQ-015 A MAC beat SHALL occur when registered a_valid AND b_valid are both 1; otherwise accumulator holds.
REQ-016 Product SHALL be full 2*DATA_WIDTH signed, sign-extended to ACC_WIDTH; sum computed at ACC_WIDTH+1 bits.
REQ-017 SATURATE=1: sum above max SHALL clamp to 2^(ACC_WIDTH-1)-1, below min to -2^(ACC_WIDTH-1), and set sat_flag; SATURATE=0: wrap, sat_flag stays 0.
REQ-018 FSM states IDLE, ACC. MAC beat with first: acc <= product (not added), sat_flag cleared then updated, -> ACC.
REQ-019 In ACC, MAC beat without first/last: acc <= acc + product.
REQ-020 MAC beat with last (in ACC or with first same beat): final sum SHALL be activated and loaded into result register; acc <= final sum; -> IDLE.
REQ-021 res_valid SHALL assert the cycle after the last beat's accumulate edge (2 cycles after last_in sampled); res_out stable while res_valid && !res_ready.
REQ-022 res_valid SHALL drop on cycle after res_valid && res_ready, unless a new result loads that cycle (stays 1, new value).
REQ-023 New result loading while res_valid && !res_ready SHALL overwrite and pulse overrun.
REQ-024 MAC beat without first while IDLE SHALL be ignored (acc unchanged) and pulse proto_err.
REQ-025 first in ACC SHALL restart the tile (discard partial sum), no error.
REQ-026 Activation: mode 0 passthrough; mode 1 negative -> 0; mode 2 negative -> sum >>> LEAKY_SHIFT; non-negative unchanged.
REQ-027 pre_act SHALL equal the accumulator register.

Reset
REQ-028 rst_n low SHALL asynchronously clear all registers: every output 0, FSM IDLE; mid-tile reset discards partial sum and pending result.

Structure
REQ-029 ACT_MODE encodings and the FSM state typedef SHALL live in shared package pe_pkg.
REQ-030 Activation SHALL be sub-module pe_act (combinational, parameters ACC_WIDTH, ACT_MODE, LEAKY_SHIFT).

Verification
REQ-031 Tile A={1,2,3}, B={4,5,6}, first on beat 0, last on beat 2, res_ready=1 -> res_out=32, single res_valid pulse.
REQ-032 ACT_MODE=1, A={-2,3}, B={5,1} -> res_out=0, pre_act=-7; ACT_MODE=2, LEAKY_SHIFT=1, same -> res_out=-4.
REQ-033 DATA_WIDTH=16, ACC_WIDTH=32, SATURATE=1, 3 beats of 32767*32767 -> res_out=2147483647, sat_flag=1; next tile first clears sat_flag.
REQ-034 res_ready=0, two back-to-back single-beat tiles (3*3 then 2*2) -> overrun pulse, res_out=4 held until res_ready=1.
REQ-035 Valid beat without first after reset -> proto_err pulse, pre_act=0; rst_n low mid-tile -> all outputs 0 immediately, next tile result correct.
REQ-036 a_valid_in=1, b_valid_in=0 -> no accumulate, a_out/a_valid_out appear 1 cycle later unchanged.
